// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: active-low segment
// patterns (bit6=a .. bit0=g), special digit codes and the readback FSM states.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIG_BLANK = 4'hE;
  localparam logic [3:0] DIG_BAD   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } scan_state_e;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational inverse of the segment encoder: active-low pattern to BCD,
// with blank mapped to DIG_BLANK and anything unrecognised flagged as bad.
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code,
  output logic       bad
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    code = DIG_BAD;
    bad  = 1'b0;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = DIG_BLANK;
      default:   bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_readback.sv
// Readback monitor for a multiplexed 7-segment bus: captures each digit once it
// has settled, assembles frames, and publishes a value after it stays stable.
module seg_scan_readback
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    valid,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    an_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int STB_W = $clog2(STABLE_FRAMES + 1);

  scan_state_e             state, state_next;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    multi_q;
  logic [CNT_W-1:0]        settle_cnt, cnt_next;
  logic [IDX_W-1:0]        idx, idx_next, idx_in;
  logic [NUM_DIGITS-1:0]   seen, seen_next;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_next, prev_frame;
  logic [STB_W-1:0]        stable_cnt, stb_next;

  logic                    an_onehot, an_multi, an_chg, seg_chg;
  logic                    capture, frame_complete, publish;
  logic [3:0]              dec_code;
  logic                    dec_bad;

  seg_to_bcd u_dec (
    .seg  (seg_in),
    .code (dec_code),
    .bad  (dec_bad)
  );

  always_comb begin
    an_onehot = ($countones(~an_in) == 1);
    an_multi  = ($countones(~an_in) > 1);
    an_chg    = (an_in != an_q);
    seg_chg   = (seg_in != seg_q);
    idx_in    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_in[i]) idx_in = IDX_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    else        state <= state_next;
  end

  // Output/datapath comb: settle counting, capture decision and frame bookkeeping.
  always_comb begin
    cnt_next = settle_cnt;
    idx_next = idx;
    if (an_onehot && an_chg) begin
      cnt_next = CNT_W'(1);
      idx_next = idx_in;
    end else if (an_onehot && state == ST_SETTLE) begin
      cnt_next = seg_chg ? CNT_W'(1) : settle_cnt + CNT_W'(1);
    end
    capture = an_onehot && (an_chg || state == ST_SETTLE)
              && (cnt_next == CNT_W'(SETTLE_CYCLES));

    shadow_next = shadow;
    seen_next   = seen;
    if (capture) begin
      shadow_next[4*idx_next +: 4] = dec_code;
      seen_next[idx_next]          = 1'b1;
    end
    frame_complete = capture && (&seen_next);

    if (shadow_next != prev_frame)                 stb_next = STB_W'(1);
    else if (stable_cnt == STB_W'(STABLE_FRAMES))  stb_next = stable_cnt;
    else                                           stb_next = stable_cnt + STB_W'(1);
    publish = frame_complete && (stb_next == STB_W'(STABLE_FRAMES));
  end

  // Next-state comb
  always_comb begin
    state_next = state;
    if (!an_onehot)                             state_next = ST_IDLE;
    else if (an_chg)                            state_next = capture ? ST_HOLD : ST_SETTLE;
    else if (state == ST_SETTLE && capture)     state_next = ST_HOLD;
  end

  // NOTE: shadow has no reset; seen guarantees every entry is rewritten before a frame is used.
  always_ff @(posedge clk) begin
    shadow <= shadow_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      multi_q     <= 1'b0;
      settle_cnt  <= '0;
      idx         <= '0;
      seen        <= '0;
      prev_frame  <= '0;
      stable_cnt  <= '0;
      digits_out  <= '0;
      valid       <= 1'b0;
      frame_done  <= 1'b0;
      pattern_err <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      an_q        <= an_in;
      seg_q       <= seg_in;
      multi_q     <= an_multi;
      settle_cnt  <= cnt_next;
      idx         <= idx_next;
      seen        <= frame_complete ? '0 : seen_next;
      frame_done  <= frame_complete;
      pattern_err <= capture && dec_bad;
      an_err      <= an_multi && !multi_q;
      if (frame_complete) begin
        prev_frame <= shadow_next;
        stable_cnt <= stb_next;
      end
      if (publish) begin
        digits_out <= shadow_next;
        valid      <= 1'b1;
      end
    end
  end

endmodule
